ppu_fb_writer: RTL and testbench

//  Consumes the PPU pixel stream (2-bit colour index + valid), applies BGP shade mapping and packs 4 px/byte.

---
 rtl/ppu_fb_writer.sv | 190 +++++++++++++++++++
 tb/tb_ppu_fb_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_fb_writer.sv
`timescale 1ns/1ps
// ppu_fb_writer: maps PPU colour indices through BGP, packs 4 px/byte and
// streams {addr,byte} into a double-buffered framebuffer through a small FIFO.
module ppu_fb_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LINE_PX    = 160,
  parameter int LINES      = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PX_IN,
  input  logic        PX_valid,
  input  logic [1:0]  PPU_MODE,
  input  logic [7:0]  BGP,
  input  logic        ERR_CLR,
  output logic [13:0] FB_ADDR,
  output logic [7:0]  FB_DATA,
  output logic        FB_WR,
  input  logic        FB_READY,
  output logic        DISP_BANK,
  output logic        FRAME_DONE,
  output logic        OVF,
  output logic        LINE_ERR
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [7:0]    LPX       = 8'(LINE_PX);
  localparam logic [7:0]    LAST_LINE = 8'(LINES - 1);
  localparam logic [13:0]   BANK_SZ   = 14'((LINE_PX / 4) * LINES);

  typedef enum logic [1:0] {S_WAIT, S_ACTIVE, S_LEND, S_FEND} state_t;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } fb_wr_t;

  state_t        r_state;
  logic [7:0]    r_px_x;
  logic [7:0]    r_line;
  logic [7:0]    r_pack;
  logic [1:0]    r_pcnt;
  logic          r_wbank;
  logic          r_disp;
  logic          r_fdone;
  logic          r_ovf;
  logic          r_lerr;
  logic          r_stg_vld;
  fb_wr_t        r_stg;

  fb_wr_t        r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_shade;
  logic [7:0]    w_pack_nxt;
  logic          w_px_take;
  logic [13:0]   w_line14;
  logic [13:0]   w_base;
  logic [13:0]   w_addr;
  logic [2:0]    w_pad_sh;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_ovf_set;
  logic          w_lerr_set;
  logic          w_frame_fin;

  always_comb begin
    w_shade    = BGP[{PX_IN, 1'b0} +: 2];
    w_pack_nxt = {r_pack[5:0], w_shade};
    w_px_take  = (r_state == S_ACTIVE) && PX_valid && (r_px_x < LPX);
    // line*40 as two shifts; bank offset is one full frame of bytes
    w_line14   = 14'(r_line);
    w_base     = (w_line14 << 5) + (w_line14 << 3) + (r_wbank ? BANK_SZ : 14'd0);
    w_addr     = w_base + 14'(r_px_x[7:2]);
    // partial byte: shift the 1-3 collected shades up to the MSBs
    w_pad_sh   = {2'(~r_pcnt + 2'd1), 1'b0};
    w_full     = (r_cnt == FULL_CNT);
    w_pop      = (r_cnt != '0) && FB_READY;
    w_push_ok  = r_stg_vld && !w_full;
    w_ovf_set  = r_stg_vld && w_full;
    w_lerr_set = ((r_state == S_LEND) && (r_px_x != LPX)) ||
                 ((r_state == S_WAIT) && (PPU_MODE == 2'd1) && (r_line != 8'd0));
    w_frame_fin = !r_stg_vld && ((r_cnt == '0) || ((r_cnt == CW'(1)) && w_pop));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_WAIT;
      r_px_x    <= '0;
      r_line    <= '0;
      r_pack    <= '0;
      r_pcnt    <= '0;
      r_wbank   <= 1'b0;
      r_disp    <= 1'b1;
      r_fdone   <= 1'b0;
      r_ovf     <= 1'b0;
      r_lerr    <= 1'b0;
      r_stg_vld <= 1'b0;
      r_stg     <= '0;
    end else begin
      r_stg_vld <= 1'b0;
      r_fdone   <= 1'b0;
      r_ovf     <= w_ovf_set  | (r_ovf  & ~ERR_CLR);
      r_lerr    <= w_lerr_set | (r_lerr & ~ERR_CLR);
      case (r_state)
        S_WAIT: begin
          if (PPU_MODE == 2'd3)
            r_state <= S_ACTIVE;
          else if (PPU_MODE == 2'd1 && r_line != 8'd0)
            r_line <= '0;
        end
        S_ACTIVE: begin
          if (w_px_take) begin
            r_pack <= w_pack_nxt;
            r_px_x <= r_px_x + 8'd1;
            r_pcnt <= r_pcnt + 2'd1;
            if (r_pcnt == 2'd3) begin
              r_stg_vld  <= 1'b1;
              r_stg.addr <= w_addr;
              r_stg.data <= w_pack_nxt;
            end
          end
          if (PPU_MODE != 2'd3)
            r_state <= S_LEND;
        end
        S_LEND: begin
          if (r_pcnt != 2'd0) begin
            r_stg_vld  <= 1'b1;
            r_stg.addr <= w_addr;
            r_stg.data <= r_pack << w_pad_sh;
          end
          r_px_x <= '0;
          r_pcnt <= '0;
          r_pack <= '0;
          if (r_line == LAST_LINE) begin
            r_state <= S_FEND;
          end else begin
            r_line  <= r_line + 8'd1;
            r_state <= S_WAIT;
          end
        end
        S_FEND: begin
          if (w_frame_fin) begin
            r_fdone <= 1'b1;
            r_wbank <= ~r_wbank;
            r_disp  <= ~r_disp;
            r_line  <= '0;
            r_state <= S_WAIT;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  // write FIFO; a full FIFO drops the staged byte, counters keep moving
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wp] <= r_stg;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign FB_WR      = (r_cnt != '0);
  assign FB_ADDR    = r_mem[r_rp].addr;
  assign FB_DATA    = r_mem[r_rp].data;
  assign DISP_BANK  = r_disp;
  assign FRAME_DONE = r_fdone;
  assign OVF        = r_ovf;
  assign LINE_ERR   = r_lerr;

endmodule

// File: tb/tb_ppu_fb_writer.sv
`timescale 1ns/1ps
// Directed bench for ppu_fb_writer: line packing, palette, frame swap,
// back-pressure overflow, short line padding and mid-frame reset.
module tb_ppu_fb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  PX_IN = '0;
  logic        PX_valid = 1'b0;
  logic [1:0]  PPU_MODE = '0;
  logic [7:0]  BGP = 8'hE4;
  logic        ERR_CLR = 1'b0;
  logic [13:0] FB_ADDR;
  logic [7:0]  FB_DATA;
  logic        FB_WR;
  logic        FB_READY = 1'b1;
  logic        DISP_BANK;
  logic        FRAME_DONE;
  logic        OVF;
  logic        LINE_ERR;

  ppu_fb_writer #(.FIFO_DEPTH(4), .LINE_PX(160), .LINES(144)) dut (
    .clk(clk), .rst(rst), .PX_IN(PX_IN), .PX_valid(PX_valid), .PPU_MODE(PPU_MODE),
    .BGP(BGP), .ERR_CLR(ERR_CLR), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_WR(FB_WR),
    .FB_READY(FB_READY), .DISP_BANK(DISP_BANK), .FRAME_DONE(FRAME_DONE), .OVF(OVF),
    .LINE_ERR(LINE_ERR)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [13:0] qa[$];
  logic [7:0]  qd[$];
  logic [13:0] last_addr = '0;
  logic [13:0] fd_addr = '0;
  int          fd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // accepted writes and frame pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (rst && FB_WR && FB_READY) begin
      qa.push_back(FB_ADDR);
      qd.push_back(FB_DATA);
      last_addr = FB_ADDR;
    end
    if (FRAME_DONE) begin
      fd_cnt++;
      fd_addr = last_addr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pat 0..3: constant index, pat 4: index cycles 0,1,2,3
  task automatic run_line(input int npx, input int pat);
    PPU_MODE = 2'd3;
    tick(1);
    for (int i = 0; i < npx; i++) begin
      PX_valid = 1'b1;
      PX_IN    = (pat == 4) ? i[1:0] : pat[1:0];
      tick(1);
    end
    PX_valid = 1'b0;
    PPU_MODE = 2'd0;
    tick(3);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (FB_WR && k < 500) begin
      tick(1);
      k++;
    end
    chk({tag, "_drain"}, FB_WR, 1'b0);
    tick(2);
  endtask

  task automatic chk_line(input string tag, input int n, input int base,
                          input logic [7:0] d, input logic [7:0] dlast);
    chk({tag, "_count"}, qa.size(), n);
    for (int i = 0; i < n && i < qa.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), qa[i], base + i);
      chk($sformatf("%s_data%0d", tag, i), qd[i], (i == n - 1) ? dlast : d);
    end
  endtask

  task automatic pulse_clr();
    ERR_CLR = 1'b1;
    tick(1);
    ERR_CLR = 1'b0;
    tick(1);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, seen;
    logic [13:0] ha;
    logic [7:0]  hd;
    logic        hv;

    // reset state
    tick(2);
    chk("rst_wr", FB_WR, 1'b0);
    chk("rst_addr", FB_ADDR, 14'd0);
    chk("rst_data", FB_DATA, 8'd0);
    chk("rst_disp", DISP_BANK, 1'b1);
    chk("rst_fdone", FRAME_DONE, 1'b0);
    chk("rst_ovf", OVF, 1'b0);
    chk("rst_lerr", LINE_ERR, 1'b0);
    rst = 1'b1;
    tick(2);

    // line 0: BGP=E4, all index 3 -> FF at 0..39
    BGP = 8'hE4;
    qa.delete(); qd.delete();
    run_line(160, 3);
    drain("l0");
    chk_line("l0", 40, 0, 8'hFF, 8'hFF);
    chk("l0_lerr", LINE_ERR, 1'b0);

    // line 1: BGP=1B, indices 0,1,2,3 -> shades 3,2,1,0 = E4
    BGP = 8'h1B;
    qa.delete(); qd.delete();
    run_line(160, 4);
    drain("l1");
    chk_line("l1", 40, 40, 8'hE4, 8'hE4);

    // line 2: 158 px index 2 -> AA, last byte A0 padded, LINE_ERR
    BGP = 8'hE4;
    qa.delete(); qd.delete();
    run_line(158, 2);
    drain("l2");
    chk_line("l2", 40, 80, 8'hAA, 8'hA0);
    chk("l2_lerr", LINE_ERR, 1'b1);
    pulse_clr();
    chk("l2_lerr_clr", LINE_ERR, 1'b0);

    // line 3: index 1 -> 55, RAM stalled 30 cycles mid-line
    qa.delete(); qd.delete();
    bad = 0; seen = 0; hv = 1'b0; ha = '0; hd = '0;
    fork
      run_line(160, 1);
      begin
        tick(20);
        FB_READY = 1'b0;
        repeat (30) begin
          @(negedge clk);
          if (FB_WR) begin
            if (hv && (FB_ADDR !== ha || FB_DATA !== hd)) bad++;
            ha = FB_ADDR; hd = FB_DATA; hv = 1'b1;
            seen++;
          end
        end
        @(posedge clk); #1;
        FB_READY = 1'b1;
      end
    join
    drain("l3");
    chk("l3_hold", bad, 0);
    chk("l3_stall_seen", seen > 10, 1'b1);
    chk("l3_ovf", OVF, 1'b1);
    chk("l3_dropped", qa.size() < 40, 1'b1);
    chk("l3_first_addr", qa[0], 14'd120);
    chk("l3_first_data", qd[0], 8'h55);
    chk("l3_last_addr", qa[qa.size()-1], 14'd159);
    chk("l3_last_data", qd[qd.size()-1], 8'h55);
    pulse_clr();
    chk("l3_ovf_clr", OVF, 1'b0);

    // rest of frame, lines 4..143
    fd_cnt = 0;
    for (int ln = 4; ln < 144; ln++) begin
      if (ln == 143) chk("f_disp_before", DISP_BANK, 1'b1);
      qa.delete(); qd.delete();
      run_line(160, 0);
      drain("fr");
    end
    tick(5);
    chk("f_done_cnt", fd_cnt, 1);
    chk("f_done_addr", fd_addr, 14'd5759);
    chk("f_disp_after", DISP_BANK, 1'b0);
    chk("f_lerr", LINE_ERR, 1'b0);

    // next frame line 0 lands in bank 1
    qa.delete(); qd.delete();
    run_line(160, 3);
    drain("nf");
    chk_line("nf", 40, 5760, 8'hFF, 8'hFF);

    // mid-frame reset with 3 bytes queued
    FB_READY = 1'b0;
    PPU_MODE = 2'd3;
    tick(1);
    for (int i = 0; i < 12; i++) begin
      PX_valid = 1'b1; PX_IN = 2'd1;
      tick(1);
    end
    PX_valid = 1'b0;
    tick(2);
    chk("mr_wr_before", FB_WR, 1'b1);
    rst = 1'b0;
    #1;
    chk("mr_wr", FB_WR, 1'b0);
    chk("mr_disp", DISP_BANK, 1'b1);
    chk("mr_addr", FB_ADDR, 14'd0);
    PPU_MODE = 2'd0;
    FB_READY = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    qa.delete(); qd.delete();
    run_line(160, 2);
    drain("mr");
    chk_line("mr", 40, 0, 8'hAA, 8'hAA);

    // V_BLANK after one line is a short frame: LINE_ERR, restart at line 0
    PPU_MODE = 2'd1;
    tick(2);
    PPU_MODE = 2'd0;
    tick(1);
    chk("sf_lerr", LINE_ERR, 1'b1);
    chk("sf_disp", DISP_BANK, 1'b1);
    qa.delete(); qd.delete();
    run_line(160, 3);
    drain("sf");
    chk("sf_first_addr", qa.size() > 0 ? qa[0] : 14'h3FFF, 14'd0);
    chk("sf_count", qa.size(), 40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
